// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
//   Shared definitions for the seven-segment display path.
//   - state_t  : converter FSM encoding (ST_IDLE / ST_SHIFT / ST_DONE)
//   - BCD_W, NUM_DIGITS, MAX_DISPLAY : digit geometry and largest showable value
//   - SAT_DIGIT : digit value shown on every position when the value overflows
// ---------------------------------------------------------------------------
package sseg_pkg;

  localparam int BCD_W       = 4;
  localparam int NUM_DIGITS  = 4;
  localparam int MAX_DISPLAY = 9999;

  localparam logic [BCD_W-1:0] SAT_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble nibble adjust: out = in >= 5 ? in + 3 : in.
//   Ports:
//     din   in  BCD_W  BCD nibble before the shift
//     dout  out BCD_W  adjusted nibble
// ---------------------------------------------------------------------------
module bcd_add3
  import sseg_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3). A start pulse while idle
//   captures bin_in; BIN_W shift cycles later the four digits, the overflow
//   flag and (optionally) the leading-zero blank mask are registered together
//   and done pulses for one cycle. Outputs hold between conversions.
//
//   Optional feature macro: LZ_BLANK_EN (adds the blank output port).
//
//   Ports:
//     clk     in   1      system clock, rising edge
//     rst_n   in   1      asynchronous active-low reset
//     start   in   1      conversion request, sampled only while busy=0
//     bin_in  in   BIN_W  unsigned value captured on the accepting edge
//     busy    out  1      conversion in progress
//     done    out  1      one-cycle pulse, outputs just updated
//     ovf     out  1      last value exceeded MAX_DISPLAY (digits show 9999)
//     digit1  out  4      ones digit
//     digit2  out  4      tens digit
//     digit3  out  4      hundreds digit
//     digit4  out  4      thousands digit
//     blank   out  4      [LZ_BLANK_EN] leading-zero blank, bit0=digit1
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
  import sseg_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4
`ifdef LZ_BLANK_EN
  ,
  output logic [3:0]       blank
`endif
);

  localparam int ITER_W = $clog2(BIN_W + 1);
  localparam int SCR_W  = BCD_W * NUM_DIGITS;

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   bin_reg;
  logic [SCR_W-1:0]   bcd_reg;
  logic [SCR_W-1:0]   bcd_adj;
  logic [SCR_W-1:0]   bcd_shift;
  logic [SCR_W-1:0]   bcd_final;
  logic [ITER_W-1:0]  iter_reg;
  logic               ovf_pend_reg;
  logic               last_shift;
  logic               busy_reg, done_reg, ovf_reg;
  logic [SCR_W-1:0]   digits_reg;
  // Thousands nibble's post-adjust MSB would shift past digit4; it is only
  // non-zero for values above 9999, which are saturated anyway.
  logic               unused_carry;

  // Nibble adjust on all four scratch digits ahead of the shift.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      bcd_add3 u_add3 (
        .din  (bcd_reg[gi*BCD_W +: BCD_W]),
        .dout (bcd_adj[gi*BCD_W +: BCD_W])
      );
    end
  endgenerate

  assign unused_carry = bcd_adj[SCR_W-1];
  assign bcd_shift    = {bcd_adj[SCR_W-2:0], bin_reg[BIN_W-1]};
  assign last_shift   = (iter_reg == ITER_W'(BIN_W - 1));
  assign bcd_final    = ovf_pend_reg ? {NUM_DIGITS{SAT_DIGIT}} : bcd_reg;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg      <= '0;
      bcd_reg      <= '0;
      iter_reg     <= '0;
      ovf_pend_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      digits_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            bin_reg      <= bin_in;
            bcd_reg      <= '0;
            iter_reg     <= '0;
            ovf_pend_reg <= (32'(bin_in) > MAX_DISPLAY);
            busy_reg     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bcd_reg  <= bcd_shift;
          bin_reg  <= bin_reg << 1;
          iter_reg <= iter_reg + ITER_W'(1);
        end
        ST_DONE: begin
          digits_reg <= bcd_final;
          ovf_reg    <= ovf_pend_reg;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LZ_BLANK_EN
  logic [3:0] blank_reg;

  // A digit blanks only when it and every digit to its left are zero;
  // the ones digit always stays lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_reg <= 4'b1110;
    end else if (state_reg == ST_DONE) begin
      blank_reg <= {(bcd_final[15:12] == 4'd0),
                    (bcd_final[15:8]  == 8'd0),
                    (bcd_final[15:4]  == 12'd0),
                    1'b0};
    end
  end

  assign blank = blank_reg;
`endif

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign ovf    = ovf_reg;
  assign digit1 = digits_reg[3:0];
  assign digit2 = digits_reg[7:4];
  assign digit3 = digits_reg[11:8];
  assign digit4 = digits_reg[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq. Expected results are pushed to a
//   queue when a conversion is started and popped when done pulses.
//   Packed result layout: {ovf, digit4, digit3, digit2, digit1, blank}.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  localparam int BIN_W   = 14;
  localparam int LATENCY = BIN_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy, done, ovf;
  logic [3:0]       digit1, digit2, digit3, digit4;
`ifdef LZ_BLANK_EN
  logic [3:0]       blank;
`endif

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];

  bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .digit4 (digit4)
`ifdef LZ_BLANK_EN
    ,
    .blank  (blank)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: decimal digits by division, saturate above 9999.
  function automatic logic [20:0] model(input int v);
    logic [3:0] d1, d2, d3, d4, b;
    logic       o;
    if (v > 9999) begin
      o = 1'b1; d1 = 4'd9; d2 = 4'd9; d3 = 4'd9; d4 = 4'd9;
    end else begin
      o  = 1'b0;
      d1 = 4'(v % 10);
      d2 = 4'((v / 10) % 10);
      d3 = 4'((v / 100) % 10);
      d4 = 4'((v / 1000) % 10);
    end
    b = 4'b0000;
`ifdef LZ_BLANK_EN
    b[3] = (d4 == 0);
    b[2] = (d4 == 0) && (d3 == 0);
    b[1] = (d4 == 0) && (d3 == 0) && (d2 == 0);
`endif
    return {o, d4, d3, d2, d1, b};
  endfunction

  function automatic logic [20:0] observed();
    logic [3:0] b;
    b = 4'b0000;
`ifdef LZ_BLANK_EN
    b = blank;
`endif
    return {ovf, digit4, digit3, digit2, digit1, b};
  endfunction

  // Drive a request at the falling edge; returns 1ns after the accepting edge
  // with start still asserted.
  task automatic start_conv(input int v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = BIN_W'(v);
    exp_q.push_back(model(v));
    @(posedge clk);
    #1;
  endtask

  // Count rising edges until done is seen (or the budget expires).
  task automatic wait_done(input int budget, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [20:0] e;
    rst_n = 1'b0;
    #2;
    e = model(0);
    checks++;
    if (observed() !== e || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got %h busy %b done %b want %h busy 0 done 0", observed(), busy, done, e);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: outputs %h", observed());
  endtask

  task automatic test_zero();
    int n; bit seen; logic [20:0] e;
    start_conv(0);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy got %b want 1", busy);
    end
    wait_done(40, n, seen);
    checks++;
    if (!seen || n != LATENCY) begin
      errors++;
      $display("FAIL zero_latency got %0d (seen %b) want %0d", n, seen, LATENCY);
    end
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL zero_result got %h want %h", observed(), e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width got %b want 0", done);
    end
    $display("zero: latency %0d result %h", n, e);
  endtask

  task automatic test_values();
    int vals[8];
    int n; bit seen; logic [20:0] e;
    vals = '{1234, 5, 80, 999, 10000, 16383, 0, 0};
    vals[6] = int'($urandom_range(0, 9999));
    vals[7] = int'($urandom_range(0, 16383));
    foreach (vals[i]) begin
      start_conv(vals[i]);
      start = 1'b0;
      wait_done(40, n, seen);
      checks++;
      if (!seen || n != LATENCY) begin
        errors++;
        $display("FAIL value_latency[%0d] got %0d want %0d", vals[i], n, LATENCY);
      end
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL value_result[%0d] got %h want %h", vals[i], observed(), e);
      end
      $display("value %0d: result %h", vals[i], observed());
    end
  endtask

  task automatic test_back_to_back();
    int vals[2];
    int n; bit seen; logic [20:0] e;
    vals = '{9999, 12000};
    foreach (vals[i]) begin
      start_conv(vals[i]);
      start = 1'b0;
      wait_done(40, n, seen);
      checks++;
      if (!seen || n != LATENCY || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_latency[%0d] got %0d busy %b want %0d busy 0", vals[i], n, busy, LATENCY);
      end
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL b2b_result[%0d] got %h want %h", vals[i], observed(), e);
      end
      $display("back_to_back %0d: result %h", vals[i], observed());
    end
  endtask

  task automatic test_start_held();
    int n; int extra; bit seen; logic [20:0] e;
    start_conv(42);
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      bin_in = BIN_W'($urandom);
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL held_busy cycle %0d got %b want 1", n, busy);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (!seen || n != LATENCY) begin
      errors++;
      $display("FAIL held_latency got %0d want %0d", n, LATENCY);
    end
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL held_result got %h want %h", observed(), e);
    end
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL held_extra_done got %0d want 0", extra);
    end
    $display("start_held 42: result %h extra_done %0d", observed(), extra);
  endtask

  task automatic test_reset_mid();
    int n; int dones; bit seen; logic [20:0] e;
    start_conv(5678);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    e = model(0);
    checks++;
    if (observed() !== e || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values got %h busy %b done %b want %h busy 0 done 0", observed(), busy, done, e);
    end
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midreset_done got %0d want 0", dones);
    end
    start_conv(5678);
    start = 1'b0;
    wait_done(40, n, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || n != LATENCY || observed() !== e) begin
      errors++;
      $display("FAIL midreset_retry got %h latency %0d want %h latency %0d", observed(), n, e, LATENCY);
    end
    $display("reset_mid 5678: retry result %h", observed());
  endtask

  task automatic test_blank();
    int vals[3];
    int n; bit seen; logic [20:0] e;
    vals = '{42, 7, 305};
    foreach (vals[i]) begin
      start_conv(vals[i]);
      start = 1'b0;
      wait_done(40, n, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || observed() !== e) begin
        errors++;
        $display("FAIL blank_result[%0d] got %h want %h", vals[i], observed(), e);
      end
      $display("blank %0d: result %h", vals[i], observed());
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    test_blank();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
